// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        StBoot  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StIssue = 3'd3,
        StHalt  = 3'd4
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [1:0] addr_lsbs);
        return addr_lsbs != 2'b00;
    endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential PC+4, branch/jump target mux and
// word-alignment check of the selected address.
module pc_next_logic
    import fetch_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_src_i,
    input  logic [XLEN-1:0] pc_target_i,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            misaligned_o
);

    always_comb begin
        // Wraps modulo 2^XLEN by construction.
        pc_plus4_o   = pc_i + XLEN'(4);
        pc_next_o    = pc_src_i ? pc_target_i : pc_plus4_o;
        misaligned_o = is_misaligned(pc_next_o[1:0]);
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the fetched instruction stable until the control path retires it.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    input  logic            Hold,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instr,
    output logic [6:0]      op,
    output logic [2:0]      funct3,
    output logic            funct7b5,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            InstrValid,
    output logic [XLEN-1:0] InstrCount,
    output logic            Fault
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_count_q, instr_count_d;
    logic            valid_q, valid_d;
    logic            fault_q, fault_d;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_next;
    logic            next_misaligned;

    pc_next_logic #(
        .XLEN (XLEN)
    ) u_pc_next (
        .pc_i         (pc_q),
        .pc_src_i     (PCSrc),
        .pc_target_i  (PCTarget),
        .pc_plus4_o   (pc_plus4),
        .pc_next_o    (pc_next),
        .misaligned_o (next_misaligned)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_count_d = instr_count_q;
        valid_d       = valid_q;
        fault_d       = fault_q;

        case (state_q)
            StBoot: begin
                state_d = StReq;
            end
            StReq: begin
                if (imem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!Hold) begin
                    instr_count_d = instr_count_q + XLEN'(1);
                    valid_d       = 1'b0;
                    // A misaligned next PC halts with PC still naming the culprit.
                    if (next_misaligned) begin
                        fault_d = 1'b1;
                        state_d = StHalt;
                    end else begin
                        pc_d    = pc_next;
                        state_d = StReq;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            instr_count_q <= '0;
            valid_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_count_q <= instr_count_d;
            valid_q       <= valid_d;
            fault_q       <= fault_d;
        end
    end

    always_comb begin
        imem_req   = (state_q == StReq);
        imem_addr  = pc_q;
        Instr      = instr_q;
        op         = instr_q[6:0];
        funct3     = instr_q[14:12];
        funct7b5   = instr_q[30];
        PC         = pc_q;
        PCPlus4    = pc_plus4;
        InstrValid = valid_q;
        InstrCount = instr_count_q;
        Fault      = fault_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized fetch/retire traffic checked
// against a PC/count model and a sparse instruction memory.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n, rst2_n;
    logic        pc_src, hold, gnt, rvalid;
    logic [31:0] pc_target, rdata;

    logic        req1, req2;
    logic [31:0] addr1, addr2, instr1, instr2, pc1, pc2, pcp4_1, pcp4_2, cnt1, cnt2;
    logic [6:0]  op1, op2;
    logic [2:0]  f3_1, f3_2;
    logic        f7_1, f7_2, valid1, valid2, fault1, fault2;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic        m_fault;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fetch_unit dut1 (
        .clk(clk), .rst_n(rst_n), .PCSrc(pc_src), .PCTarget(pc_target), .Hold(hold),
        .imem_req(req1), .imem_addr(addr1), .imem_gnt(gnt), .imem_rvalid(rvalid),
        .imem_rdata(rdata), .Instr(instr1), .op(op1), .funct3(f3_1), .funct7b5(f7_1),
        .PC(pc1), .PCPlus4(pcp4_1), .InstrValid(valid1), .InstrCount(cnt1), .Fault(fault1)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst2_n), .PCSrc(pc_src), .PCTarget(pc_target), .Hold(hold),
        .imem_req(req2), .imem_addr(addr2), .imem_gnt(gnt), .imem_rvalid(rvalid),
        .imem_rdata(rdata), .Instr(instr2), .op(op2), .funct3(f3_2), .funct7b5(f7_2),
        .PC(pc2), .PCPlus4(pcp4_2), .InstrValid(valid2), .InstrCount(cnt2), .Fault(fault2)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    // Memory responder: waits for a request, grants after gnt_delay, answers next cycle.
    // Returns at the negedge where the instruction is in ISSUE.
    task automatic do_fetch(input bit sel, input int gnt_delay, output bit ok,
                            output logic [31:0] addr, output bit stable, output int req_cyc);
        ok = 1'b0; stable = 1'b1; addr = '0; req_cyc = 0;
        for (int i = 0; i < 20; i++) begin
            if ((sel ? req2 : req1) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) return;
        addr    = sel ? addr2 : addr1;
        req_cyc = cyc;
        for (int i = 0; i < gnt_delay; i++) begin
            gnt = 1'b0;
            @(negedge clk);
            if ((sel ? req2 : req1) !== 1'b1 || (sel ? addr2 : addr1) !== addr) stable = 1'b0;
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt    = 1'b0;
        rvalid = 1'b1;
        rdata  = word_at(addr);
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = $urandom;
    endtask

    task automatic retire(input bit src, input logic [31:0] tgt);
        logic [31:0] nxt;
        pc_src    = src;
        pc_target = tgt;
        hold      = 1'b0;
        @(negedge clk);
        hold    = 1'b1;
        pc_src  = 1'b0;
        m_count = m_count + 32'd1;
        nxt     = src ? tgt : m_pc + 32'd4;
        if (nxt[1:0] != 2'b00) m_fault = 1'b1;
        else m_pc = nxt;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rst2_n = 1'b0; hold = 1'b1; gnt = 1'b0; rvalid = 1'b0;
        pc_src = 1'b0; pc_target = '0; rdata = '0;
        repeat (2) @(negedge clk);
        checks++; if (pc1 !== 32'h0) $display("FAIL reset_pc got %h want %h", pc1, 32'h0);
        else passes++;
        checks++; if (instr1 !== 32'h13) $display("FAIL reset_instr got %h want 13", instr1);
        else passes++;
        checks++;
        if ({valid1, req1, fault1} !== 3'b000)
            $display("FAIL reset_flags got valid/req/fault=%b want 000", {valid1, req1, fault1});
        else passes++;
        checks++; if (cnt1 !== 32'h0) $display("FAIL reset_count got %h want 0", cnt1);
        else passes++;
        checks++;
        if (pc2 !== 32'hFFFF_FFFC) $display("FAIL reset_pc2 got %h want fffffffc", pc2);
        else passes++;
        rst_n = 1'b1;
        m_pc = 32'h0; m_count = '0; m_fault = 1'b0;
        @(negedge clk);
        checks++;
        if (req1 !== 1'b1 || addr1 !== 32'h0)
            $display("FAIL boot_to_req got req=%b addr=%h want req=1 addr=0", req1, addr1);
        else passes++;
    endtask

    task automatic test_sequential;
        bit ok, st;
        logic [31:0] a, w;
        int rc, prev;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            do_fetch(1'b0, 0, ok, a, st, rc);
            w = word_at(a);
            checks++; if (!ok) $display("FAIL seq_req_timeout got none want req");
            else passes++;
            checks++; if (a !== m_pc) $display("FAIL seq_addr got %h want %h", a, m_pc);
            else passes++;
            if (i > 0) begin
                checks++;
                if (rc - prev != 3) $display("FAIL seq_throughput got %0d want 3", rc - prev);
                else passes++;
            end
            prev = rc;
            checks++;
            if (instr1 !== w || pc1 !== m_pc || valid1 !== 1'b1)
                $display("FAIL seq_issue got instr=%h pc=%h v=%b want %h %h 1",
                         instr1, pc1, valid1, w, m_pc);
            else passes++;
            checks++;
            if (op1 !== w[6:0] || f3_1 !== w[14:12] || f7_1 !== w[30])
                $display("FAIL seq_fields got %h/%h/%b want %h/%h/%b",
                         op1, f3_1, f7_1, w[6:0], w[14:12], w[30]);
            else passes++;
            checks++;
            if (pcp4_1 !== m_pc + 32'd4) $display("FAIL seq_pcplus4 got %h want %h", pcp4_1, m_pc + 32'd4);
            else passes++;
            retire(1'b0, 32'h0);
            checks++; if (valid1 !== 1'b0) $display("FAIL seq_valid_fall got %b want 0", valid1);
            else passes++;
        end
        checks++; if (cnt1 !== m_count) $display("FAIL seq_count got %h want %h", cnt1, m_count);
        else passes++;
    endtask

    task automatic test_branch;
        bit ok, st, src;
        logic [31:0] a, tgt;
        int rc;
        do_fetch(1'b0, 0, ok, a, st, rc);
        retire(1'b1, 32'h100);
        do_fetch(1'b0, 0, ok, a, st, rc);
        checks++;
        if (!ok || a !== 32'h100) $display("FAIL branch_addr got ok=%b addr=%h want 100", ok, a);
        else passes++;
        checks++; if (pc1 !== 32'h100) $display("FAIL branch_pc got %h want 100", pc1);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            src = 1'($urandom_range(0, 1));
            tgt = $urandom & 32'hFFFF_FFFC;
            retire(src, tgt);
            do_fetch(1'b0, int'($urandom_range(0, 3)), ok, a, st, rc);
            checks++;
            if (!ok || a !== m_pc || instr1 !== word_at(m_pc) || cnt1 !== m_count)
                $display("FAIL branch_rand got addr=%h instr=%h cnt=%h want %h %h %h",
                         a, instr1, cnt1, m_pc, word_at(m_pc), m_count);
            else passes++;
        end
    endtask

    task automatic test_hold;
        bit ok, st;
        logic [31:0] a, w;
        int rc;
        retire(1'b0, 32'h0);
        do_fetch(1'b0, 4, ok, a, st, rc);
        w = word_at(m_pc);
        checks++;
        if (!ok || !st || a !== m_pc)
            $display("FAIL hold_gnt_wait got ok=%b stable=%b addr=%h want 1 1 %h", ok, st, a, m_pc);
        else passes++;
        for (int i = 0; i < 5; i++) begin
            pc_src    = 1'b1;
            pc_target = $urandom | 32'h1;
            rvalid    = 1'b1;
            rdata     = ~w;
            @(negedge clk);
            checks++;
            if (instr1 !== w || pc1 !== m_pc || cnt1 !== m_count || valid1 !== 1'b1 || fault1 !== 1'b0)
                $display("FAIL hold_frozen got instr=%h pc=%h cnt=%h v=%b f=%b want %h %h %h 1 0",
                         instr1, pc1, cnt1, valid1, fault1, w, m_pc, m_count);
            else passes++;
        end
        pc_src = 1'b0;
        rvalid = 1'b0;
        retire(1'b0, 32'h0);
        checks++;
        if (cnt1 !== m_count || valid1 !== 1'b0)
            $display("FAIL hold_release got cnt=%h v=%b want %h 0", cnt1, valid1, m_count);
        else passes++;
    endtask

    task automatic test_fault;
        bit ok, st;
        logic [31:0] a;
        int rc;
        do_fetch(1'b0, 0, ok, a, st, rc);
        retire(1'b1, 32'h102);
        checks++;
        if (fault1 !== m_fault || valid1 !== 1'b0 || pc1 !== m_pc || cnt1 !== m_count)
            $display("FAIL fault_entry got f=%b v=%b pc=%h cnt=%h want %b 0 %h %h",
                     fault1, valid1, pc1, cnt1, m_fault, m_pc, m_count);
        else passes++;
        gnt = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (req1 !== 1'b0 || fault1 !== 1'b1)
                $display("FAIL fault_halt got req=%b f=%b want 0 1", req1, fault1);
            else passes++;
        end
        gnt = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok, st;
        logic [31:0] a;
        int rc;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0; m_count = '0; m_fault = 1'b0;
        @(negedge clk);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (instr1 !== 32'h13 || pc1 !== 32'h0 || req1 !== 1'b0 || fault1 !== 1'b0)
            $display("FAIL midreset got instr=%h pc=%h req=%b f=%b want 13 0 0 0",
                     instr1, pc1, req1, fault1);
        else passes++;
        @(negedge clk);
        rst_n  = 1'b1;
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (instr1 !== 32'h13 || valid1 !== 1'b0)
                $display("FAIL stray_rvalid got instr=%h v=%b want 13 0", instr1, valid1);
            else passes++;
        end
        rvalid = 1'b0;
        do_fetch(1'b0, 0, ok, a, st, rc);
        checks++;
        if (!ok || a !== 32'h0 || instr1 !== word_at(32'h0))
            $display("FAIL midreset_refetch got addr=%h instr=%h want 0 %h", a, instr1, word_at(32'h0));
        else passes++;
    endtask

    task automatic test_wrap;
        bit ok, st;
        logic [31:0] a, w;
        int rc;
        rst_n = 1'b0;
        @(negedge clk);
        rst2_n = 1'b1;
        m_pc = 32'hFFFF_FFFC; m_count = '0; m_fault = 1'b0;
        do_fetch(1'b1, 1, ok, a, st, rc);
        w = word_at(m_pc);
        checks++;
        if (!ok || a !== 32'hFFFF_FFFC || pcp4_2 !== 32'h0)
            $display("FAIL wrap_pcplus4 got addr=%h pcp4=%h want fffffffc 0", a, pcp4_2);
        else passes++;
        checks++;
        if (instr2 !== w || op2 !== w[6:0] || f3_2 !== w[14:12] || f7_2 !== w[30])
            $display("FAIL wrap_instr got %h want %h", instr2, w);
        else passes++;
        force dut2.instr_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut2.instr_count_q;
        @(negedge clk);
        m_count = 32'hFFFF_FFFF;
        checks++; if (cnt2 !== m_count) $display("FAIL count_preload got %h want %h", cnt2, m_count);
        else passes++;
        retire(1'b0, 32'h0);
        checks++; if (cnt2 !== m_count) $display("FAIL count_wrap got %h want %h", cnt2, m_count);
        else passes++;
        do_fetch(1'b1, 0, ok, a, st, rc);
        checks++;
        if (!ok || a !== m_pc || pc2 !== m_pc || valid2 !== 1'b1 || fault2 !== 1'b0)
            $display("FAIL wrap_addr got addr=%h pc=%h v=%b f=%b want %h %h 1 0",
                     a, pc2, valid2, fault2, m_pc, m_pc);
        else passes++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_hold();
        test_fault();
        test_reset_mid();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
